// File: rtl/shift_stream_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_stream_stage_pkg : shared constants and request type           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package shift_stream_stage_pkg;

  localparam int SHIFT_WIDTH = 8;
  localparam int SHIFT_AMT_W = 3;
  localparam int OVF_CNT_W   = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 8'd255;

  typedef struct packed {
    logic [SHIFT_WIDTH-1:0] data;
    logic [SHIFT_AMT_W-1:0] shft;
  } shift_req_t;

endpackage
`default_nettype wire

// File: rtl/Barrel_Shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Barrel_Shifter : combinational 8-bit logical left shifter, zero fill |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module Barrel_Shifter (
  input  logic [7:0] data_i,
  input  logic [2:0] shft_i,
  output logic [7:0] data_o
);

  logic [7:0] w_stage1;
  logic [7:0] w_stage2;

  assign w_stage1 = shft_i[0] ? {data_i[6:0],   1'b0}    : data_i;
  assign w_stage2 = shft_i[1] ? {w_stage1[5:0], 2'b00}   : w_stage1;
  assign data_o   = shft_i[2] ? {w_stage2[3:0], 4'b0000} : w_stage2;

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_fifo : DEPTH x WIDTH circular FIFO with level/full/empty      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stream_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] C_PTR_ONE  = PW'(1);
  localparam logic [PW:0]   C_LVL_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   C_LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (level_q == C_LVL_FULL);
  assign empty_o = (level_q == '0);
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    if (w_push && !w_pop)      level_d = level_q + C_LVL_ONE;
    else if (w_pop && !w_push) level_d = level_q - C_LVL_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/shift_stream_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_stream_stage : FIFO-buffered, output-registered shift stage    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module shift_stream_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHW-1:0]         in_shft,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_ovf,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             ovf_count,
  input  logic                   ovf_clr
);

  import shift_stream_stage_pkg::*;

  localparam logic [SHIFT_WIDTH-1:0] C_ONES    = '1;
  localparam logic [OVF_CNT_W-1:0]   C_CNT_ONE = OVF_CNT_W'(1);

  shift_req_t             w_push_req;
  shift_req_t             w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_load;
  logic                   w_xfer;
  logic                   w_ovf_next;
  logic [SHIFT_WIDTH-1:0] w_shifted;

  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_ovf_q, out_ovf_d;
  logic [OVF_CNT_W-1:0]   ovf_count_q, ovf_count_d;

  assign w_push_req.data = in_data;
  assign w_push_req.shft = in_shft;

  stream_fifo #(
    .WIDTH ($bits(shift_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (w_push_req),
    .pop_i   (w_load),
    .rdata_o (w_head),
    .level_o (level),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  Barrel_Shifter u_shifter (
    .data_i (w_head.data),
    .shft_i (w_head.shft),
    .data_o (w_shifted)
  );

  // Mask selects the top shft bits of the head operand, i.e. those pushed out.
  assign w_ovf_next = |(w_head.data & ~(C_ONES >> w_head.shft));

  assign in_ready = !w_fifo_full;
  assign w_load   = !w_fifo_empty && (!out_valid_q || out_ready);
  assign w_xfer   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (w_load) begin
      out_valid_d = 1'b1;
      out_data_d  = w_shifted;
      out_ovf_d   = w_ovf_next;
    end else if (w_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr)
      ovf_count_d = '0;
    else if (w_xfer && out_ovf_q && (ovf_count_q != OVF_CNT_MAX))
      ovf_count_d = ovf_count_q + C_CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_count = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_stream_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_stream_stage : randomized bench with queue reference model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_shift_stream_stage;

  localparam int W = 8;
  localparam int S = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_shft;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic [2:0]   level;
  logic [7:0]   ovf_count;
  logic         ovf_clr;

  always #5 clk = ~clk;

  shift_stream_stage #(.WIDTH(W), .SHW(S), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shft   (in_shft),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .level     (level),
    .ovf_count (ovf_count),
    .ovf_clr   (ovf_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of pending requests plus one output slot.
  logic [10:0] m_fifo[$];
  bit          m_vld;
  logic [7:0]  m_data;
  bit          m_ovf;
  int          m_cnt;

  function automatic void model_reset();
    m_fifo.delete();
    m_vld  = 0;
    m_data = '0;
    m_ovf  = 0;
    m_cnt  = 0;
  endfunction

  function automatic int unsigned full_shift(input logic [7:0] d, input logic [2:0] s);
    int unsigned v;
    v = int'(d);
    return v << s;
  endfunction

  function automatic void model_step();
    bit          xfer;
    bit          can_push;
    bit          load;
    bit          ovf_pre;
    logic [10:0] r;
    int unsigned p;
    xfer     = m_vld && out_ready;
    can_push = (m_fifo.size() < D);
    load     = (m_fifo.size() > 0) && (!m_vld || out_ready);
    ovf_pre  = m_ovf;
    if (load) begin
      r      = m_fifo.pop_front();
      p      = full_shift(r[10:3], r[2:0]);
      m_data = p[7:0];
      m_ovf  = (p > 255);
      m_vld  = 1;
    end else if (xfer) begin
      m_vld = 0;
    end
    if (in_valid && can_push) m_fifo.push_back({in_data, in_shft});
    if (ovf_clr) m_cnt = 0;
    else if (xfer && ovf_pre && m_cnt < 255) m_cnt++;
  endfunction

  task automatic compare_all();
    chk("in_ready",  in_ready,  (m_fifo.size() != D));
    chk("out_valid", out_valid, m_vld);
    chk("level",     level,     m_fifo.size());
    chk("ovf_count", ovf_count, m_cnt);
    chk("out_data",  out_data,  m_data);
    chk("out_ovf",   out_ovf,   m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] bp_exp [5];
  logic [7:0] d8;
  logic [2:0] s3;

  initial begin
    in_valid = 0; in_data = '0; in_shft = '0; out_ready = 0; ovf_clr = 0;
    rst = 1;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_level",     level,     0);
    compare_all();
    @(negedge clk);
    rst = 0;

    // Single overflowing request
    in_valid = 1; in_data = 8'h99; in_shft = 3'd4; out_ready = 1;
    cycle();
    in_valid = 0;
    cycle();
    chk("t1_valid", out_valid, 1);
    chk("t1_data",  out_data,  8'h90);
    chk("t1_ovf",   out_ovf,   1);
    cycle();
    chk("t1_cnt",   ovf_count, 1);

    // No-overflow shift then pass-through
    in_valid = 1; in_data = 8'h0F; in_shft = 3'd4;
    cycle();
    in_data = 8'hA5; in_shft = 3'd0;
    cycle();
    chk("t2_data", out_data, 8'hF0);
    chk("t2_ovf",  out_ovf,  0);
    in_valid = 0;
    cycle();
    chk("t2_pass_data", out_data, 8'hA5);
    chk("t2_pass_ovf",  out_ovf,  0);
    cycle();

    // Back-pressure: six pushes, five accepted
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 8'($urandom); in_shft = 3'($urandom);
      bp_exp[i] = 8'(full_shift(in_data, in_shft));
      cycle();
    end
    chk("bp_level_full", level,    4);
    chk("bp_in_ready",   in_ready, 0);
    in_data = 8'($urandom);
    cycle();
    in_valid = 0;
    chk("bp_head", out_data, bp_exp[0]);
    out_ready = 1;
    for (int k = 1; k < 5; k++) begin
      cycle();
      chk("bp_drain", out_data, bp_exp[k]);
    end
    cycle();
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_level", level,     0);

    // Back-to-back streaming with shift amounts 0..7
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = 8'($urandom); in_shft = 3'(i % 8);
      cycle();
      if (i > 0) chk("stream_level", level, 1);
    end
    in_valid = 0;
    repeat (3) cycle();

    // Saturation of ovf_count, then clear colliding with a transfer
    for (int i = 0; i < 310; i++) begin
      in_valid = 1; in_data = 8'hFF; in_shft = 3'($urandom_range(1, 7));
      cycle();
    end
    chk("sat_cnt", ovf_count, 255);
    ovf_clr = 1;
    cycle();
    chk("clr_cnt", ovf_count, 0);
    ovf_clr = 0;
    in_valid = 0;
    repeat (3) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_shft   = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    in_valid = 0; ovf_clr = 0; out_ready = 1;
    repeat (6) cycle();

    // Asynchronous reset with level=3 and a held output
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'($urandom); in_shft = 3'($urandom);
      cycle();
    end
    in_valid = 0;
    chk("ar_pre_level", level,     3);
    chk("ar_pre_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data",  out_data,  0);
    chk("ar_ovf",   out_ovf,   0);
    chk("ar_level", level,     0);
    chk("ar_ready", in_ready,  1);
    chk("ar_cnt",   ovf_count, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    repeat (3) begin
      cycle();
      chk("ar_no_stale", out_valid, 0);
    end
    in_valid = 1; d8 = 8'h01; s3 = 3'd7; in_data = d8; in_shft = s3;
    cycle();
    in_valid = 0;
    cycle();
    chk("ar_new_valid", out_valid, 1);
    chk("ar_new_data",  out_data,  8'h80);
    chk("ar_new_ovf",   out_ovf,   0);
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_stream_stage.md
Name: shift_stream_stage

Overview:
- Registered streaming wrapper that feeds and consumes the team's combinational 8-bit logical-left shifter, Barrel_Shifter.
- Accepts (data, shift-amount) requests over valid/ready and buffers them in a small FIFO.
- Drives the FIFO head through one Barrel_Shifter instance and registers the result with an overflow flag on a valid/ready output.
- Sits between the request producer and any downstream consumer, so the shifter is fully timing-isolated on both sides.

Parameters:
- WIDTH, 8: data width. Must match the Barrel_Shifter instance, so only 8 is supported.
- SHW, 3: shift-amount width; shift range is 0..WIDTH-1.
- DEPTH, 4: input FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at the clk edge.
- in_data  input  WIDTH  operand.
- in_shft  input  SHW  left-shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready at the clk edge.
- out_data  output  WIDTH  shifted result, in_data << in_shft, zero-filled.
- out_ovf  output  1  1 iff any '1' bit was shifted out.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH. Excludes the output register.
- ovf_count  output  8  saturating count of delivered results with out_ovf=1.
- ovf_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_ovf=0, level=0, ovf_count=0.
  - FIFO read/write pointers are 0 and in_ready=1 after reset.
  - Reset mid-operation discards all buffered and in-flight items without emitting them.
- FIFO:
  - Circular buffer with pointers of log2(DEPTH) bits; pointers wrap naturally.
  - in_ready = (level != DEPTH). It does not depend on out_ready in the same cycle.
  - When full, no push occurs even if a pop happens that cycle.
  - Push and pop in the same cycle leave level unchanged.
- Shift path:
  - FIFO head {data, shft} drives Barrel_Shifter combinationally.
  - ovf_next = OR of head data bits [WIDTH-1 : WIDTH-shft] when shft>0; ovf_next = 0 when shft=0.
- Output register:
  - load = (level != 0) && (!out_valid || out_ready).
  - On load: out_data <= shifter output, out_ovf <= ovf_next, out_valid <= 1, and the FIFO pops.
  - Else if out_ready && out_valid: out_valid <= 0. out_data and out_ovf hold their last value.
  - When out_valid=1 and out_ready=0, out_data and out_ovf are stable.
- Latency and throughput:
  - A request accepted at edge N is presented with out_valid=1 after edge N+1.
  - Sustained throughput is 1 item per cycle when out_ready=1.
  - Order is strictly preserved.
- ovf_count:
  - Increments on each output transfer (out_valid && out_ready) with out_ovf=1.
  - Saturates at 255.
  - ovf_clr has priority: if clear and a transfer occur in the same cycle, the result is 0.

Decomposition:
- Shared package holds:
  - constants SHIFT_WIDTH=8, SHIFT_AMT_W=3, OVF_CNT_W=8, OVF_CNT_MAX=255;
  - a packed typedef for the request, {data[7:0], shft[2:0]}.
- One natural sub-module, stream_fifo: generic DEPTH x (WIDTH+SHW) FIFO with level, full and empty outputs.
- Barrel_Shifter is instantiated unchanged. The overflow OR and the output register live in the top.

Test Plan:
- Single request in_data=0x99, in_shft=4, out_ready=1: after 2 edges out_data=0x90, out_ovf=1. After the transfer, ovf_count=1.
- in_data=0x0F, in_shft=4 -> out_data=0xF0, out_ovf=0. Then in_data=0xA5, in_shft=0 -> out_data=0xA5, out_ovf=0 (pass-through).
- Back-pressure with out_ready=0, pushing 6 requests:
  - 5 are accepted (1 held in the output register, 4 in the FIFO); level=4 and in_ready=0 on the 6th.
  - Then raise out_ready: the 5 results drain in order, one per cycle, and level returns to 0.
- Streaming 16 back-to-back requests with shft cycling 0..7 and out_ready=1: one result per cycle, all matching (data<<shft)&0xFF. Push and pop in the same cycle keep level constant.
- ovf_count saturation and clear:
  - 300 overflowing transfers -> ovf_count=255.
  - ovf_clr asserted in the same cycle as an overflowing transfer -> ovf_count=0.
- Async rst pulse mid-stream with the FIFO at level=3 and out_valid=1:
  - Outputs go to reset values immediately, without waiting for clk.
  - No stale item appears after release.
  - A new request 0x01, shft=7 yields 0x80, ovf=0.
